short_location_expander: RTL

//  Inverse of the short leading-one detector in the offset-divider path. Takes a

---
 rtl/short_location_expander_if.sv | 34 +++
 rtl/short_location_expander.sv | 138 +++++++++++++
 2 files changed

// File: rtl/short_location_expander_if.sv
// short_location_expander_if
//   Bundles the code-in and word-out handshakes of the short location expander.
//   slave  : the expander side (consumes codes, produces words and the error count)
//   master : the producer/consumer side (drives codes and out_ready)
//   Signals: in_valid/in_ready/in_loc/in_mant  -- compressed code handshake
//            out_valid/out_ready/out_word/out_err -- reconstructed word handshake
//            err_count -- saturating count of accepted illegal codes
`timescale 1ns/1ps
interface short_location_expander_if #(
    parameter int WORD_W = 10,
    parameter int LOC_W  = 4,
    parameter int MANT_W = 4,
    parameter int CNT_W  = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [LOC_W-1:0]  in_loc;
    logic [MANT_W-1:0] in_mant;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_word;
    logic              out_err;
    logic [CNT_W-1:0]  err_count;

    modport slave (
        input  in_valid, in_loc, in_mant, out_ready,
        output in_ready, out_valid, out_word, out_err, err_count
    );

    modport master (
        output in_valid, in_loc, in_mant, out_ready,
        input  in_ready, out_valid, out_word, out_err, err_count
    );
endinterface

// File: rtl/short_location_expander.sv
// short_location_expander
//   Rebuilds a WORD_W-bit magnitude from a compressed code made of the
//   leading-one location (0 = zero word, k = bit k-1 is the leading one) and the
//   MANT_W bits directly below that leading one, MSB-aligned. Two registered
//   stages, one code per cycle, valid/ready on both sides.
//   Ports:
//     clk    -- rising-edge clock
//     rst_n  -- asynchronous active-low reset, flushes both stages
//     bus    -- short_location_expander_if.slave (code in, word out, err_count)
//   Optional build macro MIDPOINT_FILL_EN: when the mantissa does not reach the
//   bottom of the word, set the bit just below it so the result sits at the
//   midpoint of the quantization interval instead of its lower edge.
`timescale 1ns/1ps
module short_location_expander #(
    parameter int WORD_W = 10,
    parameter int LOC_W  = 4,
    parameter int MANT_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    short_location_expander_if.slave  bus
);
    localparam int TW   = WORD_W + MANT_W;
    localparam int SH_W = $clog2(TW + 2);

    // Stage 1 state
    logic              s1_valid_r;
    logic [LOC_W-1:0]  s1_loc_r;
    logic [MANT_W-1:0] s1_mant_r;
    logic [WORD_W-1:0] s1_onehot_r;
    logic              s1_illegal_r;

    // Stage 2 state (drives the outputs directly)
    logic              out_valid_r;
    logic [WORD_W-1:0] out_word_r;
    logic              out_err_r;
    logic [CNT_W-1:0]  err_count_r;

    logic              s2_load_s;
    logic              s1_load_s;
    logic              in_xfer_s;
    logic              in_illegal_s;
    logic [WORD_W-1:0] in_onehot_s;
    logic [SH_W-1:0]   mant_shift_s;
    logic [WORD_W-1:0] mant_bits_s;
    logic [WORD_W-1:0] fill_bits_s;
    logic [WORD_W-1:0] compose_s;

    // Stage enables; in_ready follows out_ready combinationally so a full pipe
    // still accepts a new code in the cycle the output drains.
    always_comb begin
        s2_load_s = !out_valid_r || bus.out_ready;
        s1_load_s = !s1_valid_r || s2_load_s;
        in_xfer_s = bus.in_valid && s1_load_s;
    end

    // Input decode: one-hot of in_loc-1 (all zero for loc 0 and for illegal codes)
    always_comb begin
        in_illegal_s = (bus.in_loc > LOC_W'(WORD_W));
        in_onehot_s  = {WORD_W{1'b0}};
        for (int i = 0; i < WORD_W; i++) begin
            in_onehot_s[i] = (bus.in_loc == LOC_W'(i + 1));
        end
    end

    // Word composition from the stage-1 fields
    always_comb begin
        // Mantissa MSB starts at bit TW-1 of {mant, zeros}; shifting right by
        // TW+1-loc lands it on bit loc-2, the first position below the leading
        // one. Mantissa bits that fall under bit 0 drop out of the truncation.
        mant_shift_s = SH_W'(TW + 1) - SH_W'(s1_loc_r);
        mant_bits_s  = WORD_W'({s1_mant_r, {WORD_W{1'b0}}} >> mant_shift_s);
`ifdef MIDPOINT_FILL_EN
        // Bit just below the mantissa; shifts out entirely when the mantissa
        // already reaches bit 0.
        fill_bits_s  = s1_onehot_r >> (MANT_W + 1);
`else
        fill_bits_s  = {WORD_W{1'b0}};
`endif
        if (|s1_onehot_r) begin
            compose_s = s1_onehot_r | mant_bits_s | fill_bits_s;
        end else begin
            compose_s = {WORD_W{1'b0}};
        end
    end

    // Stage 1 register: location, mantissa, decode and illegal flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r   <= 1'b0;
            s1_loc_r     <= {LOC_W{1'b0}};
            s1_mant_r    <= {MANT_W{1'b0}};
            s1_onehot_r  <= {WORD_W{1'b0}};
            s1_illegal_r <= 1'b0;
        end else if (s1_load_s) begin
            s1_valid_r   <= bus.in_valid;
            s1_loc_r     <= bus.in_loc;
            s1_mant_r    <= bus.in_mant;
            s1_onehot_r  <= in_onehot_s;
            s1_illegal_r <= in_illegal_s;
        end else begin
            s1_valid_r   <= s1_valid_r;
        end
    end

    // Stage 2 register: composed word and its error flag, held while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_word_r  <= {WORD_W{1'b0}};
            out_err_r   <= 1'b0;
        end else if (s2_load_s) begin
            out_valid_r <= s1_valid_r;
            out_word_r  <= compose_s;
            out_err_r   <= s1_illegal_r;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Saturating count of illegal codes, counted when they are accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count_r <= {CNT_W{1'b0}};
        end else if (in_xfer_s && in_illegal_s && !(&err_count_r)) begin
            err_count_r <= err_count_r + CNT_W'(1);
        end else begin
            err_count_r <= err_count_r;
        end
    end

    assign bus.in_ready  = s1_load_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_word  = out_word_r;
    assign bus.out_err   = out_err_r;
    assign bus.err_count = err_count_r;
endmodule
